branch_predictor_table: RTL and testbench

Parametrised branch history table of N-bit saturating counters, indexed by low PC bits, with one registered prediction read port, one update port with same-cycle forwarding, and saturating update/mispredict statistics counters. It sits between the fetch stage, which reads a prediction per fetched branch, and the execute stage, which writes back the resolved outcome. It is the generalised successor of the fixed 8-row, 2-bit table: depth, counter width, reset state and statistics width are parameters, and the counter update is fully defined.

---
 rtl/bpt_pkg.sv | 34 +++
 rtl/sat_counter.sv | 39 +++
 rtl/branch_predictor_table.sv | 105 ++++++++++
 tb/tb_branch_predictor_table.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bpt_pkg.sv
// Shared definitions for the branch history table: counter state names,
// default parameter values and the saturating step helpers.
package bpt_pkg;

  // Names of the four states of a 2-bit predictor counter.
  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not-taken
    WNT = 2'b01,  // weakly not-taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } ctr2_state_e;

  localparam int DEF_INDEX_BITS = 5;
  localparam int DEF_CTR_BITS   = 2;
  localparam int DEF_INIT_STATE = 1;
  localparam int DEF_STAT_BITS  = 16;

  // Increment that sticks at max_val; callers pass zero-extended operands.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) res = max_val;
    else                res = val + 32'd1;
    return res;
  endfunction

  // Decrement that sticks at zero.
  function automatic logic [31:0] sat_dec(input logic [31:0] val);
    logic [31:0] res;
    if (val == 32'd0) res = 32'd0;
    else              res = val - 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// One table entry: a CTR_BITS-wide saturating counter. The combinational
// next value is exported so the top level can forward it to a same-cycle read.
module sat_counter
  import bpt_pkg::*;
#(
  parameter int CTR_BITS   = DEF_CTR_BITS,
  parameter int INIT_STATE = DEF_INIT_STATE
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_taken,
  output logic [CTR_BITS-1:0] o_state,
  output logic [CTR_BITS-1:0] o_next
);

  localparam logic [31:0] CTR_MAX = 32'((64'd1 << CTR_BITS) - 64'd1);

  logic [CTR_BITS-1:0] r_state;
  logic [CTR_BITS-1:0] w_next;

  // Saturating step toward the resolved outcome.
  always_comb begin
    w_next = r_state;
    if (i_taken) w_next = CTR_BITS'(sat_inc(32'(r_state), CTR_MAX));
    else         w_next = CTR_BITS'(sat_dec(32'(r_state)));
  end

  // Counter register: reset to the initial state, otherwise step only when updated.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_state <= CTR_BITS'(INIT_STATE);
    else if (i_en) r_state <= w_next;
    else           r_state <= r_state;
  end

  assign o_state = r_state;
  assign o_next  = w_next;

endmodule

// File: rtl/branch_predictor_table.sv
// Branch history table of saturating counters with a registered read port,
// an update port forwarded to same-index reads, and saturating statistics.
module branch_predictor_table
  import bpt_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int CTR_BITS   = DEF_CTR_BITS,
  parameter int INIT_STATE = DEF_INIT_STATE,
  parameter int STAT_BITS  = DEF_STAT_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_en,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic                  i_wr_taken,
  input  logic                  i_clr_stats,
  output logic                  o_pred_taken,
  output logic [CTR_BITS-1:0]   o_pred_state,
  output logic                  o_pred_valid,
  output logic [STAT_BITS-1:0]  o_stat_updates,
  output logic [STAT_BITS-1:0]  o_stat_mispredicts
);

  localparam int          ENTRIES  = 2 ** INDEX_BITS;
  localparam logic [31:0] STAT_MAX = 32'((64'd1 << STAT_BITS) - 64'd1);

  logic [CTR_BITS-1:0]  w_state [ENTRIES];
  logic [CTR_BITS-1:0]  w_next  [ENTRIES];
  logic [CTR_BITS-1:0]  w_rd_val;
  logic [CTR_BITS-1:0]  w_wr_old;
  logic                 w_mispredict;

  logic                 r_pred_taken;
  logic [CTR_BITS-1:0]  r_pred_state;
  logic                 r_pred_valid;
  logic [STAT_BITS-1:0] r_stat_updates;
  logic [STAT_BITS-1:0] r_stat_mispredicts;

  // Flat array of counters so every entry can be reset in one cycle.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    sat_counter #(
      .CTR_BITS   (CTR_BITS),
      .INIT_STATE (INIT_STATE)
    ) u_ctr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_wr_en && (i_wr_index == INDEX_BITS'(g))),
      .i_taken (i_wr_taken),
      .o_state (w_state[g]),
      .o_next  (w_next[g])
    );
  end

  // Read mux with forwarding of a same-cycle update to the same entry.
  always_comb begin
    w_rd_val = w_state[i_rd_index];
    if (i_wr_en && (i_rd_index == i_wr_index)) w_rd_val = w_next[i_rd_index];
    else                                       w_rd_val = w_state[i_rd_index];
  end

  assign w_wr_old     = w_state[i_wr_index];
  assign w_mispredict = (w_wr_old[CTR_BITS-1] != i_wr_taken);

  // Prediction register: captured on rd_en, held otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pred_taken <= 1'b0;
      r_pred_state <= '0;
      r_pred_valid <= 1'b0;
    end else begin
      r_pred_valid <= i_rd_en;
      if (i_rd_en) begin
        r_pred_state <= w_rd_val;
        r_pred_taken <= w_rd_val[CTR_BITS-1];
      end else begin
        r_pred_state <= r_pred_state;
        r_pred_taken <= r_pred_taken;
      end
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_stats) begin
      r_stat_updates     <= '0;
      r_stat_mispredicts <= '0;
    end else if (i_wr_en) begin
      r_stat_updates <= STAT_BITS'(sat_inc(32'(r_stat_updates), STAT_MAX));
      if (w_mispredict) r_stat_mispredicts <= STAT_BITS'(sat_inc(32'(r_stat_mispredicts), STAT_MAX));
      else              r_stat_mispredicts <= r_stat_mispredicts;
    end else begin
      r_stat_updates     <= r_stat_updates;
      r_stat_mispredicts <= r_stat_mispredicts;
    end
  end

  assign o_pred_taken       = r_pred_taken;
  assign o_pred_state       = r_pred_state;
  assign o_pred_valid       = r_pred_valid;
  assign o_stat_updates     = r_stat_updates;
  assign o_stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: directed scenarios plus random traffic,
// checked against an array-based model of the counter table.
module tb_branch_predictor_table;

  logic       clk = 1'b0;
  logic       rst, rd_en, wr_en, wr_taken, clr_stats;
  logic [4:0] rd_index, wr_index;

  logic        pred_taken, pred_valid, pred_taken4, pred_valid4;
  logic [1:0]  pred_state, pred_state4;
  logic [15:0] stat_updates, stat_mispredicts;
  logic [3:0]  stat_updates4, stat_mispredicts4;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_tbl [32];
  int m_pred_state, m_pred_valid;
  int m_upd16, m_mis16, m_upd4, m_mis4;

  always #5 clk = ~clk;

  branch_predictor_table #(.INDEX_BITS(5), .CTR_BITS(2), .INIT_STATE(1), .STAT_BITS(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_rd_index(rd_index),
    .i_wr_en(wr_en), .i_wr_index(wr_index), .i_wr_taken(wr_taken), .i_clr_stats(clr_stats),
    .o_pred_taken(pred_taken), .o_pred_state(pred_state), .o_pred_valid(pred_valid),
    .o_stat_updates(stat_updates), .o_stat_mispredicts(stat_mispredicts));

  branch_predictor_table #(.INDEX_BITS(5), .CTR_BITS(2), .INIT_STATE(1), .STAT_BITS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_rd_index(rd_index),
    .i_wr_en(wr_en), .i_wr_index(wr_index), .i_wr_taken(wr_taken), .i_clr_stats(clr_stats),
    .o_pred_taken(pred_taken4), .o_pred_state(pred_state4), .o_pred_valid(pred_valid4),
    .o_stat_updates(stat_updates4), .o_stat_mispredicts(stat_mispredicts4));

  // Apply one cycle of stimulus, advance the model across the edge, sample #1 later.
  task automatic cycle(input bit r, input bit rd, input int ri, input bit wr, input int wi,
                       input bit tk, input bit clr);
    int oldv, newv;
    rst = r; rd_en = rd; rd_index = 5'(ri); wr_en = wr; wr_index = 5'(wi);
    wr_taken = tk; clr_stats = clr;
    @(posedge clk);
    oldv = m_tbl[wi];
    newv = tk ? ((oldv + 1 > 3) ? 3 : oldv + 1) : ((oldv == 0) ? 0 : oldv - 1);
    if (r) begin
      for (int i = 0; i < 32; i++) m_tbl[i] = 1;
      m_pred_state = 0; m_pred_valid = 0;
      m_upd16 = 0; m_mis16 = 0; m_upd4 = 0; m_mis4 = 0;
    end else begin
      if (rd) m_pred_state = (wr && ri == wi) ? newv : m_tbl[ri];
      m_pred_valid = rd ? 1 : 0;
      if (clr) begin
        m_upd16 = 0; m_mis16 = 0; m_upd4 = 0; m_mis4 = 0;
      end else if (wr) begin
        m_upd16 = (m_upd16 >= 65535) ? 65535 : m_upd16 + 1;
        m_upd4  = (m_upd4 >= 15) ? 15 : m_upd4 + 1;
        if ((oldv >= 2) != tk) begin
          m_mis16 = (m_mis16 >= 65535) ? 65535 : m_mis16 + 1;
          m_mis4  = (m_mis4 >= 15) ? 15 : m_mis4 + 1;
        end
      end
      if (wr) m_tbl[wi] = newv;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (pred_valid !== 1'b0 || pred_state !== 2'd0 || pred_taken !== 1'b0) begin
      n_err++; $display("FAIL reset_pred got v=%0d s=%0d t=%0d exp 0/0/0", pred_valid, pred_state, pred_taken); end
    n_vec++; if (stat_updates !== 16'd0 || stat_mispredicts !== 16'd0) begin
      n_err++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_updates, stat_mispredicts); end
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, i, 0, 0, 0, 0);
      n_vec++; if (pred_state !== 2'd1 || pred_taken !== 1'b0 || pred_valid !== 1'b1) begin
        n_err++; $display("FAIL reset_read idx %0d got s=%0d t=%0d v=%0d exp 1/0/1", i, pred_state, pred_taken, pred_valid); end
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (pred_valid !== 1'b0 || pred_state !== 2'd1) begin
      n_err++; $display("FAIL valid_drop got v=%0d s=%0d exp 0/1", pred_valid, pred_state); end
  endtask

  task automatic test_taken_saturate();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 3, 1, 3, 1, 0);
      n_vec++; if (pred_state !== 2'(m_pred_state) || pred_taken !== 1'(m_pred_state >= 2)) begin
        n_err++; $display("FAIL taken_step %0d got %0d exp %0d", k, pred_state, m_pred_state); end
    end
    n_vec++; if (stat_updates !== 16'd4 || stat_mispredicts !== 16'd1) begin
      n_err++; $display("FAIL taken_stats got %0d/%0d exp 4/1", stat_updates, stat_mispredicts); end
  endtask

  task automatic test_not_taken_floor();
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 7, 0, 0);
    cycle(0, 1, 7, 0, 0, 0, 0);
    n_vec++; if (pred_state !== 2'd0 || pred_taken !== 1'b0) begin
      n_err++; $display("FAIL nt_floor got %0d exp 0", pred_state); end
    n_vec++; if (stat_mispredicts !== 16'(m_mis16) || stat_updates !== 16'd7) begin
      n_err++; $display("FAIL nt_stats got %0d/%0d exp 7/%0d", stat_updates, stat_mispredicts, m_mis16); end
  endtask

  task automatic test_forwarding();
    cycle(0, 1, 5, 1, 5, 1, 0);
    n_vec++; if (pred_state !== 2'd2 || pred_taken !== 1'b1) begin
      n_err++; $display("FAIL fwd_same got %0d exp 2", pred_state); end
    cycle(0, 1, 6, 1, 5, 1, 0);
    n_vec++; if (pred_state !== 2'd1) begin
      n_err++; $display("FAIL fwd_other got %0d exp 1", pred_state); end
    cycle(0, 1, 5, 0, 0, 0, 0);
    n_vec++; if (pred_state !== 2'd3) begin
      n_err++; $display("FAIL fwd_after got %0d exp 3", pred_state); end
  endtask

  task automatic test_stat_saturate();
    cycle(0, 0, 0, 0, 0, 0, 1);
    // Alternating outcomes on a weakly-biased entry mispredict every time.
    for (int k = 0; k < 20; k++) cycle(0, 0, 0, 1, 10, (k % 2) == 0, 0);
    n_vec++; if (stat_mispredicts4 !== 4'd15 || stat_updates4 !== 4'd15) begin
      n_err++; $display("FAIL stat4_sat got %0d/%0d exp 15/15", stat_updates4, stat_mispredicts4); end
    n_vec++; if (stat_mispredicts !== 16'd20 || stat_updates !== 16'd20) begin
      n_err++; $display("FAIL stat16_cnt got %0d/%0d exp 20/20", stat_updates, stat_mispredicts); end
    cycle(0, 0, 0, 1, 10, 1, 1);
    n_vec++; if (stat_mispredicts4 !== 4'd0 || stat_updates4 !== 4'd0 || stat_updates !== 16'd0) begin
      n_err++; $display("FAIL clr_prio got %0d/%0d exp 0/0", stat_updates4, stat_mispredicts4); end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 0, 1, 9, 1, 0);
    cycle(0, 0, 0, 1, 9, 1, 0);
    cycle(1, 1, 9, 1, 9, 1, 0);
    n_vec++; if (pred_valid !== 1'b0 || pred_state !== 2'd0) begin
      n_err++; $display("FAIL rst_mid_pred got v=%0d s=%0d exp 0/0", pred_valid, pred_state); end
    cycle(0, 1, 9, 0, 0, 0, 0);
    n_vec++; if (pred_state !== 2'd1 || pred_valid !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_read got %0d exp 1", pred_state); end
  endtask

  task automatic test_back_to_back();
    bit rd, wr, tk, clr;
    int ri, wi;
    for (int k = 0; k < 400; k++) begin
      rd = $urandom_range(0, 3) != 0; wr = $urandom_range(0, 3) != 0;
      tk = $urandom_range(0, 1) == 1; clr = $urandom_range(0, 40) == 0;
      ri = $urandom_range(0, 3); wi = $urandom_range(0, 3);
      cycle(k == 200, rd, ri, wr, wi, tk, clr);
      n_vec++; if (pred_state !== 2'(m_pred_state) || pred_valid !== 1'(m_pred_valid) ||
                   pred_taken !== 1'(m_pred_state >= 2) || pred_state4 !== 2'(m_pred_state)) begin
        n_err++; $display("FAIL rand_pred cyc %0d got s=%0d v=%0d exp s=%0d v=%0d", k, pred_state, pred_valid, m_pred_state, m_pred_valid); end
      n_vec++; if (stat_updates !== 16'(m_upd16) || stat_mispredicts !== 16'(m_mis16) ||
                   stat_updates4 !== 4'(m_upd4) || stat_mispredicts4 !== 4'(m_mis4)) begin
        n_err++; $display("FAIL rand_stats cyc %0d got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", k,
                          stat_updates, stat_mispredicts, stat_updates4, stat_mispredicts4,
                          m_upd16, m_mis16, m_upd4, m_mis4); end
    end
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; wr_taken = 1'b0; clr_stats = 1'b0;
    rd_index = 5'd0; wr_index = 5'd0;
    for (int i = 0; i < 32; i++) m_tbl[i] = 1;
    m_pred_state = 0; m_pred_valid = 0;
    m_upd16 = 0; m_mis16 = 0; m_upd4 = 0; m_mis4 = 0;
    test_reset();
    test_taken_saturate();
    test_not_taken_floor();
    test_forwarding();
    test_stat_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
